// File: rtl/keccak_x_heep_pkg.sv
// Shared constants and types for the Keccak OBI front end: register byte offsets,
// state size and the control FSM state encoding.
package keccak_x_heep_pkg;

    localparam int KECCAK_STATE_WORDS = 50;

    localparam logic [11:0] KECCAK_DIN_BASE    = 12'h000;
    localparam logic [11:0] KECCAK_DOUT_BASE   = 12'h100;
    localparam logic [11:0] KECCAK_CTRL_OFFS   = 12'h200;
    localparam logic [11:0] KECCAK_STATUS_OFFS = 12'h204;
    localparam logic [11:0] KECCAK_IRQ_EN_OFFS = 12'h208;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } keccak_ctrl_state_e;

endpackage

// File: rtl/keccak_ctrl_fsm.sv
// Run control for the Keccak core: IDLE/START/BUSY sequencing, start pulse,
// sticky DONE flag and the capture strobe for the result bank.
module keccak_ctrl_fsm
    import keccak_x_heep_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               i_start_req,
    input  logic               i_done_clr,
    input  logic               i_core_done,
    output logic               o_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_capture,
    output keccak_ctrl_state_e o_state
);

    keccak_ctrl_state_e r_state;
    keccak_ctrl_state_e w_state_next;
    logic               r_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start_req) w_state_next = START;
            START:   w_state_next = BUSY;
            BUSY:    if (i_core_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_start   = (r_state == START);
        o_busy    = (r_state != IDLE);
        o_capture = (r_state == BUSY) && i_core_done;
        o_done    = r_done;
        o_state   = r_state;
    end

    // A completion in the same cycle as a software clear keeps DONE set.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else if (o_capture) begin
            r_done <= 1'b1;
        end else if (i_done_clr) begin
            r_done <= 1'b0;
        end
    end

endmodule

// File: rtl/keccak_obi_slave.sv
// OBI register front end for Keccak-f[1600]: DIN/DOUT banks, CTRL/STATUS/IRQ_EN.
// Optional feature macro: KECCAK_IRQ_EN (implements IRQ_EN and the interrupt).
module keccak_obi_slave
    import keccak_x_heep_pkg::*;
#(
    parameter int STATE_WORDS = KECCAK_STATE_WORDS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      keccak_start_o,
    output logic [32*STATE_WORDS-1:0] keccak_din_o,
    input  logic                      keccak_done_i,
    input  logic [32*STATE_WORDS-1:0] keccak_dout_i,
    output logic                      keccak_intr_o
);

    logic [31:0]        r_din  [STATE_WORDS];
    logic [31:0]        r_dout [STATE_WORDS];
    logic               r_rvalid;
    logic [31:0]        r_rdata;

    logic [11:0]        w_offs;
    logic [5:0]         w_word;
    logic               w_word_ok;
    logic               w_din_hit, w_dout_hit, w_ctrl_hit, w_status_hit, w_irq_hit;
    logic               w_wr, w_rd, w_idle;
    logic               w_start_req, w_done_clr;
    logic               w_busy, w_done, w_capture, w_irq_en;
    logic [31:0]        w_rdata;
    keccak_ctrl_state_e w_state;
    logic               w_unused_ok;

    // Handshake: every request is granted in its own cycle (gnt_o = req_i); the
    // response (rvalid_o with rdata_o, 0 for writes) follows exactly one cycle later.
    assign gnt_o    = req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;

    assign w_offs       = addr_i[11:0];
    assign w_word       = addr_i[7:2];
    assign w_word_ok    = int'(w_word) < STATE_WORDS;
    assign w_din_hit    = (w_offs[11:8] == KECCAK_DIN_BASE[11:8]) && w_word_ok;
    assign w_dout_hit   = (w_offs[11:8] == KECCAK_DOUT_BASE[11:8]) && w_word_ok;
    assign w_ctrl_hit   = (w_offs[11:2] == KECCAK_CTRL_OFFS[11:2]);
    assign w_status_hit = (w_offs[11:2] == KECCAK_STATUS_OFFS[11:2]);
    assign w_irq_hit    = (w_offs[11:2] == KECCAK_IRQ_EN_OFFS[11:2]);

    assign w_wr   = req_i & we_i;
    assign w_rd   = req_i & ~we_i;
    assign w_idle = (w_state == IDLE);

    assign w_start_req = w_wr & w_ctrl_hit & be_i[0] & wdata_i[0] & w_idle;
    assign w_done_clr  = w_wr & w_status_hit & be_i[0] & wdata_i[1];

    keccak_ctrl_fsm u_ctrl_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_start_req (w_start_req),
        .i_done_clr  (w_done_clr),
        .i_core_done (keccak_done_i),
        .o_start     (keccak_start_o),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_capture   (w_capture),
        .o_state     (w_state)
    );

    // The input state is frozen while a permutation is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STATE_WORDS; i++) r_din[i] <= '0;
        end else if (w_wr && w_din_hit && w_idle) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) r_din[w_word][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STATE_WORDS; i++) r_dout[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < STATE_WORDS; i++) r_dout[i] <= keccak_dout_i[i*32 +: 32];
        end
    end

    always_comb begin
        keccak_din_o = '0;
        for (int i = 0; i < STATE_WORDS; i++) keccak_din_o[i*32 +: 32] = r_din[i];
    end

`ifdef KECCAK_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && w_irq_hit && be_i[0]) begin
            r_irq_en <= wdata_i[0];
        end
    end

    assign w_irq_en = r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    assign keccak_intr_o = w_done & w_irq_en;

    always_comb begin
        w_rdata = '0;
        if (w_din_hit) begin
            w_rdata = r_din[w_word];
        end else if (w_dout_hit) begin
            w_rdata = r_dout[w_word];
        end else if (w_status_hit) begin
            w_rdata = {30'b0, w_done, w_busy};
        end else if (w_irq_hit) begin
            w_rdata = {31'b0, w_irq_en};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign w_unused_ok = ^{addr_i[31:12], addr_i[1:0], w_irq_hit};

endmodule

// File: tb/tb_keccak_obi_slave.sv
// Self-checking bench for keccak_obi_slave: OBI driver tasks, response scoreboard,
// a hand-driven core model and start-pulse monitoring.
module tb_keccak_obi_slave;

    localparam int W = 32 * 50;
`ifdef KECCAK_IRQ_EN
    localparam logic IRQ_IMPL = 1'b1;
`else
    localparam logic IRQ_IMPL = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [3:0]    be_i = 4'h0;
    logic [31:0]   addr_i = '0;
    logic [31:0]   wdata_i = '0;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          keccak_start_o;
    logic [W-1:0]  keccak_din_o;
    logic          keccak_done_i = 1'b0;
    logic [W-1:0]  keccak_dout_i = '0;
    logic          keccak_intr_o;

    logic [31:0]   exp_q[$];
    string         tag_q[$];
    logic [31:0]   din_m [50];
    int            n_checks = 0;
    int            n_errors = 0;
    int            start_cnt = 0;

    keccak_obi_slave dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .keccak_start_o (keccak_start_o),
        .keccak_din_o   (keccak_din_o),
        .keccak_done_i  (keccak_done_i),
        .keccak_dout_i  (keccak_dout_i),
        .keccak_intr_o  (keccak_intr_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every response is popped against the value queued at request time.
    always @(negedge clk_i) begin
        if (rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), rdata_o, exp_q.pop_front());
            end
        end
        if (keccak_start_o === 1'b1) start_cnt++;
    end

    // Driver tasks
    task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        check("gnt", {31'b0, gnt_o}, 32'd1);
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
        check("rvalid_latency", {31'b0, rvalid_o}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, be, addr, data, 32'd0, "wr_rdata");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus(1'b0, 4'hF, addr, 32'd0, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic done_pulse();
        keccak_done_i = 1'b1;
        @(posedge clk_i); #1;
        keccak_done_i = 1'b0;
    endtask

    initial begin
        int          w;
        int          base;
        logic [31:0] d;
        logic [3:0]  be;

        for (int i = 0; i < 50; i++) din_m[i] = '0;

        // Reset with a request present: granted but never answered
        rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h204;
        #1 check("gnt_in_reset", {31'b0, gnt_o}, 32'd1);
        @(posedge clk_i); @(posedge clk_i); #1;
        req_i = 1'b0; rst_ni = 1'b1; addr_i = '0;
        @(negedge clk_i);
        check("rvalid_reset", {31'b0, rvalid_o}, 32'd0);
        check("start_reset", {31'b0, keccak_start_o}, 32'd0);
        check("intr_reset", {31'b0, keccak_intr_o}, 32'd0);
        check("din_o_reset", keccak_din_o[31:0], 32'd0);
        rd(32'h204, 32'h0, "status_reset");
        rd(32'h000, 32'h0, "din0_reset");
        rd(32'h1C4, 32'h0, "dout49_reset");

        // DIN writes with byte enables
        wr(4'b0011, 32'h000, 32'hDEADBEEF);
        din_m[0] = 32'h0000BEEF;
        rd(32'h000, 32'h0000BEEF, "din0_be");
        rd(32'h1000, 32'h0000BEEF, "din0_alias");
        wr(4'hF, 32'h00C, 32'h33333333);
        din_m[3] = 32'h33333333;
        for (int k = 0; k < 5; k++) begin
            w  = $urandom_range(4, 49);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            wr(be, 32'(w * 4), d);
            for (int b = 0; b < 4; b++) if (be[b]) din_m[w][b*8 +: 8] = d[b*8 +: 8];
            rd(32'(w * 4), din_m[w], "din_rand");
            check("din_o_word", keccak_din_o[w*32 +: 32], din_m[w]);
        end
        wr(4'hF, 32'h100, 32'hFFFFFFFF);
        rd(32'h100, 32'h0, "dout_ro");
        rd(32'h0C8, 32'h0, "unmapped_0c8");
        wr(4'b0001, 32'h208, 32'h1);
        rd(32'h208, {31'b0, IRQ_IMPL}, "irq_en");

        // Launch: start pulse one cycle after the grant, BUSY visible immediately
        base = start_cnt;
        wr(4'b0001, 32'h200, 32'h1);
        check("start_high", {31'b0, keccak_start_o}, 32'd1);
        rd(32'h204, 32'h1, "status_busy");
        check("start_low", {31'b0, keccak_start_o}, 32'd0);
        rd(32'h200, 32'h0, "ctrl_reads0");

        // Writes while busy are acknowledged but have no effect
        wr(4'hF, 32'h00C, 32'hFFFFFFFF);
        wr(4'b0001, 32'h200, 32'h1);
        rd(32'h00C, din_m[3], "din3_busy");
        idle(2);
        check("start_once", 32'(start_cnt - base), 32'd1);

        // Completion
        for (int k = 0; k < 50; k++) keccak_dout_i[k*32 +: 32] = 32'hA5A50000 | 32'(k);
        keccak_dout_i[49*32 +: 32] = 32'h12345678;
        done_pulse();
        check("intr_done", {31'b0, keccak_intr_o}, {31'b0, IRQ_IMPL});
        rd(32'h204, 32'h2, "status_done");
        rd(32'h1C4, 32'h12345678, "dout49");
        rd(32'h100, 32'hA5A50000, "dout0");
        rd(32'h104, 32'hA5A50001, "dout1");
        wr(4'b0001, 32'h204, 32'h2);
        check("intr_cleared", {31'b0, keccak_intr_o}, 32'd0);
        rd(32'h204, 32'h0, "status_cleared");

        // DONE set beats a same-cycle W1C
        wr(4'b0001, 32'h200, 32'h1);
        idle(2);
        keccak_done_i = 1'b1;
        wr(4'b0001, 32'h204, 32'h2);
        keccak_done_i = 1'b0;
        rd(32'h204, 32'h2, "set_wins");

        // START write in the done cycle does not relaunch
        wr(4'b0001, 32'h204, 32'h2);
        base = start_cnt;
        wr(4'b0001, 32'h200, 32'h1);
        idle(2);
        keccak_done_i = 1'b1;
        wr(4'b0001, 32'h200, 32'h1);
        keccak_done_i = 1'b0;
        idle(3);
        check("no_relaunch", 32'(start_cnt - base), 32'd1);
        rd(32'h204, 32'h2, "status_after_race");

        // A done pulse while idle is ignored
        wr(4'b0001, 32'h204, 32'h2);
        keccak_dout_i[49*32 +: 32] = 32'hCAFEF00D;
        done_pulse();
        rd(32'h204, 32'h0, "idle_done_status");
        rd(32'h1C4, 32'h12345678, "idle_done_dout");

        // Reset mid-run, then a stale completion
        wr(4'b0001, 32'h200, 32'h1);
        idle(2);
        rst_ni = 1'b0;
        idle(2);
        rst_ni = 1'b1;
        done_pulse();
        check("intr_after_reset", {31'b0, keccak_intr_o}, 32'd0);
        rd(32'h204, 32'h0, "status_after_reset");
        rd(32'h1C4, 32'h0, "dout49_after_reset");
        rd(32'h100, 32'h0, "dout0_after_reset");
        rd(32'h000, 32'h0, "din0_after_reset");
        rd(32'h300, 32'h0, "unmapped_300");

        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
